// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan codes, key bit indices and the decode FSM states.
package ps2_pkg;

    // Prefix and break codes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Extended (E0-prefixed) arrow codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Normal WASD codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Held-key bit positions, shared with the car controller
    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } dec_state_e;

    // One-hot key mask for a scan code; zero for unmapped codes.
    function automatic logic [3:0] key_mask(input logic [7:0] code,
                                            input logic       ext,
                                            input logic       wasd);
        logic [3:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    m[KEY_UP]    = 1'b1;
                SC_DOWN:  m[KEY_DOWN]  = 1'b1;
                SC_LEFT:  m[KEY_LEFT]  = 1'b1;
                SC_RIGHT: m[KEY_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end else if (wasd) begin
            case (code)
                SC_W:    m[KEY_UP]    = 1'b1;
                SC_S:    m[KEY_DOWN]  = 1'b1;
                SC_A:    m[KEY_LEFT]  = 1'b1;
                SC_D:    m[KEY_RIGHT] = 1'b1;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receive front end: synchronize, glitch-filter the clock, shift in
// 11-bit frames on filtered falling edges, check framing and time out stalls.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 130000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   frame_q, frame_d;
    logic          check_q, check_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_q, tmo_d;
    logic          frame_ok;

    // Two-flop synchronizers on the asynchronous PS/2 lines (idle high)
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: flip only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    // Bit shifting, end-of-frame check request and mid-frame stall timeout
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        check_d   = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = 1'b0;
        if (fall) begin
            // Shift in from the top so the start bit ends up in bit 0
            frame_d   = {dat_s2_q, frame_q[10:1]};
            tmo_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                check_d   = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = 4'd0;
                tmo_cnt_d = '0;
                tmo_d     = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Receive state registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            bit_cnt_q   <= 4'd0;
            frame_q     <= '0;
            check_q     <= 1'b0;
            tmo_cnt_q   <= '0;
            tmo_q       <= 1'b0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            check_q     <= check_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    // Start low, stop high, odd parity over data+parity
    assign frame_ok    = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);
    assign rx_byte     = frame_q[8:1];
    assign byte_strobe = check_q & frame_ok;
    assign frame_err   = (check_q & ~frame_ok) | tmo_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to held-key vector: tracks E0/F0 prefixes and make/break
// codes so each key bit stays high exactly while that key is held.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 130000,
    parameter int unsigned ENABLE_WASD    = 1
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic       frame_err
);

    localparam logic WASD_ON = (ENABLE_WASD != 0);

    logic [7:0] rx_byte;
    logic       byte_strobe;
    logic       rx_err;
    dec_state_e state_q, state_d;
    logic [3:0] key_q, key_d;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .pclk        (pclk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .frame_err   (rx_err)
    );

    // Decode FSM state register
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Prefix tracking; a bad or stalled frame drops any pending prefix
    always_comb begin
        state_d = state_q;
        if (rx_err) begin
            state_d = StIdle;
        end else if (byte_strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_byte == SC_EXT) state_d = StExt;
                    else if (rx_byte == SC_BRK) state_d = StBrk;
                end
                StExt: begin
                    if (rx_byte == SC_BRK) state_d = StExtBrk;
                    else if (rx_byte != SC_EXT) state_d = StIdle;
                end
                StBrk:    state_d = StIdle;
                StExtBrk: state_d = StIdle;
            endcase
        end
    end

    // Key update: make ORs in the mapped bit, break clears it; prefixes map to zero
    always_comb begin
        key_d = key_q;
        if (byte_strobe) begin
            unique case (state_q)
                StIdle:   key_d = key_q | key_mask(rx_byte, 1'b0, WASD_ON);
                StExt:    key_d = key_q | key_mask(rx_byte, 1'b1, WASD_ON);
                StBrk:    key_d = key_q & ~key_mask(rx_byte, 1'b0, WASD_ON);
                StExtBrk: key_d = key_q & ~key_mask(rx_byte, 1'b1, WASD_ON);
            endcase
        end
    end

    // Held-key register
    always_ff @(posedge pclk) begin
        if (rst) begin
            key_q <= 4'b0000;
        end else begin
            key_q <= key_d;
        end
    end

    assign key       = key_q;
    assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: driver pushes expected key changes / frame errors, a
// negedge monitor pops and compares whenever either DUT produces an event.
module tb_ps2_key_decoder;

    localparam int unsigned FL  = 8;
    localparam int unsigned TMO = 2000;
    localparam int          H   = 20;   // half PS/2 bit period in pclk cycles

    logic       pclk     = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key_w1, key_w0;
    logic       ferr_w1, ferr_w0;

    always #5 pclk = ~pclk;

    ps2_key_decoder #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO),
        .ENABLE_WASD    (1)
    ) dut_wasd (
        .pclk      (pclk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key_w1),
        .frame_err (ferr_w1)
    );

    ps2_key_decoder #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO),
        .ENABLE_WASD    (0)
    ) dut_nowasd (
        .pclk      (pclk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key_w0),
        .frame_err (ferr_w0)
    );

    typedef struct {
        bit         is_err;
        logic [3:0] val;
        int         lat_lo;
        int         lat_hi;
        string      name;
    } exp_t;

    exp_t       q1[$];
    exp_t       q0[$];
    int         cyc         = 0;
    int         ref_cyc     = 0;
    int         vectors     = 0;
    int         miscompares = 0;
    bit         mon_en      = 1'b0;
    logic [3:0] prev1       = 4'b0000;
    logic [3:0] prev0       = 4'b0000;

    always @(posedge pclk) cyc <= cyc + 1;

    // which: 0 = no-WASD DUT only, 1 = WASD DUT only, 2 = both
    task automatic expect_ev(input int which, input bit is_err, input logic [3:0] val,
                             input int lo, input int hi, input string name);
        exp_t e;
        e.is_err = is_err;
        e.val    = val;
        e.lat_lo = lo;
        e.lat_hi = hi;
        e.name   = name;
        if (which != 0) q1.push_back(e);
        if (which != 1) q0.push_back(e);
    endtask

    task automatic check_ev(input int d, input bit is_err, input logic [3:0] val);
        exp_t e;
        int   lat;
        bit   empty;
        vectors++;
        lat   = cyc - ref_cyc;
        empty = (d == 1) ? (q1.size() == 0) : (q0.size() == 0);
        if (empty) begin
            miscompares++;
            $display("FAIL unexpected_event dut%0d: got err=%0b key=%b at cycle %0d, required none",
                     d, is_err, val, cyc);
            return;
        end
        if (d == 1) e = q1.pop_front();
        else e = q0.pop_front();
        if (e.is_err != is_err || (!is_err && e.val != val) ||
            lat < e.lat_lo || lat > e.lat_hi) begin
            miscompares++;
            $display("FAIL %s dut%0d: got err=%0b key=%b latency=%0d, required err=%0b key=%b latency %0d..%0d",
                     e.name, d, is_err, val, lat, e.is_err, e.val, e.lat_lo, e.lat_hi);
        end
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    // Monitor: every frame_err pulse and every key change is an event
    always @(negedge pclk) begin
        if (mon_en) begin
            if (ferr_w1) check_ev(1, 1'b1, 4'b0000);
            if (key_w1 != prev1) check_ev(1, 1'b0, key_w1);
            if (ferr_w0) check_ev(0, 1'b1, 4'b0000);
            if (key_w0 != prev0) check_ev(0, 1'b0, key_w0);
        end
        prev1 = key_w1;
        prev0 = key_w0;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        ps2_data = v;
        wait_cyc(H);
        ps2_clk = 1'b0;
        ref_cyc = cyc;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        wait_cyc(3 * H);
    endtask

    task automatic send_partial(input int n);
        send_bit(1'b0);
        for (int i = 1; i < n; i++) send_bit(1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic key_ev(input int which, input logic [3:0] val, input string name);
        expect_ev(which, 1'b0, val, FL + 2, FL + 6, name);
    endtask

    initial begin
        wait_cyc(5);
        chk("reset_key_wasd", key_w1, 4'b0000);
        chk("reset_key_nowasd", key_w0, 4'b0000);
        chk("reset_ferr_wasd", {3'b000, ferr_w1}, 4'b0000);
        chk("reset_ferr_nowasd", {3'b000, ferr_w0}, 4'b0000);
        rst    = 1'b0;
        mon_en = 1'b1;
        wait_cyc(3 * H);

        // Extended make and break of up
        key_ev(2, 4'b0001, "make_up");
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        key_ev(2, 4'b0000, "break_up");
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);

        // Two held keys, release one, then typematic repeats
        key_ev(2, 4'b0100, "make_left");
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        key_ev(2, 4'b1100, "make_right");
        send_byte(8'hE0, 0); send_byte(8'h74, 0);
        key_ev(2, 4'b1000, "break_left");
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hE0, 0); send_byte(8'h74, 0);
        end
        chk("typematic_hold", key_w1, 4'b1000);
        key_ev(2, 4'b0000, "break_right");
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h74, 0);
        // Break of a key not held: no event
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h72, 0);

        // Parity error on E0 drops the prefix; 75 alone is unmapped
        expect_ev(2, 1'b1, 4'b0000, FL + 2, FL + 6, "parity_err");
        send_byte(8'hE0, 1);
        send_byte(8'h75, 0);
        chk("after_parity_err", key_w1, 4'b0000);

        // Stalled frame times out exactly once, then decoding resumes
        expect_ev(2, 1'b1, 4'b0000, TMO, TMO + FL + 10, "timeout_err");
        send_partial(5);
        wait_cyc(TMO + 10);
        key_ev(2, 4'b0001, "make_up_after_timeout");
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        key_ev(2, 4'b0000, "break_up_after_timeout");
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);

        // Short clock glitch must not count as a bit
        ps2_clk = 1'b0;
        wait_cyc(FL - 3);
        ps2_clk = 1'b1;
        wait_cyc(3 * H);
        key_ev(2, 4'b0010, "make_down_after_glitch");
        send_byte(8'hE0, 0); send_byte(8'h72, 0);

        // Reset mid-frame clears keys and discards the partial frame
        send_partial(5);
        expect_ev(2, 1'b0, 4'b0000, 1, 3, "reset_mid_frame");
        ref_cyc = cyc;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3 * H);
        key_ev(2, 4'b0001, "make_up_after_reset");
        send_byte(8'hE0, 0); send_byte(8'h75, 0);
        key_ev(2, 4'b0000, "break_up_after_reset");
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);

        // WASD: only the WASD-enabled DUT reacts
        key_ev(1, 4'b0001, "make_w");
        send_byte(8'h1D, 0);
        chk("nowasd_ignores_w", key_w0, 4'b0000);
        key_ev(1, 4'b0000, "break_w");
        send_byte(8'hF0, 0); send_byte(8'h1D, 0);

        wait_cyc(50);
        chk("leftover_events_wasd", 4'(q1.size()), 4'd0);
        chk("leftover_events_nowasd", 4'(q0.size()), 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
